// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// Latency: mul/div results appear WIDTH+1 cycles after the accept edge; MTHI/MTLO take 1 cycle.
// Backpressure: busy is high while an op runs, and any start seen while busy is dropped, not queued.
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   start, op, a, b  request (taken only while idle) with opcode and operands
//   busy, done       busy while running; done pulses once when hi/lo hold a new result
//   dbz              last completed divide had a zero divisor (cleared on the next accepted op)
//   hi, lo           architectural HI/LO registers
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // Shared datapath: upper half is the partial product / partial remainder,
  // lower half is the multiplier / dividend being consumed bit by bit.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;        // multiplicand (mul) or divisor (div) magnitude
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d; // product/quotient needs negating
  logic               neg_rem_q, neg_rem_d; // remainder takes the dividend's sign
  logic               divz_q, divz_d;       // divide by zero in flight
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  // Operand magnitudes for signed ops (op[0] set); unsigned ops pass through raw.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_neg = op[0] & a[WIDTH-1];
  assign b_neg = op[0] & b[WIDTH-1];
  assign a_mag = a_neg ? (~a + 1'b1) : a;
  assign b_mag = b_neg ? (~b + 1'b1) : b;

  // Shift-add multiply step: add the multiplicand into the upper half when the
  // current multiplier bit is set, then shift the whole accumulator right.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : {WIDTH{1'b0}})};

  // Restoring divide step: shift the next dividend bit into the remainder and
  // try to subtract. The remainder stays below the divisor, so the shifted value
  // fits WIDTH+1 bits and bit WIDTH of the difference is a clean borrow flag.
  logic [WIDTH:0] div_shift, div_diff;
  logic           div_ge;
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opb_q};
  assign div_ge    = ~div_diff[WIDTH];

  // Sign correction applied once in FIX.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign prod_fix = neg_res_q ? (~acc_q + 1'b1) : acc_q;
  assign quo_fix  = neg_res_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    divz_d    = divz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = dbz_q;
    done_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            3'b000, 3'b001, 3'b010, 3'b011: begin
              state_d   = S_CALC;
              cnt_d     = CW'(WIDTH);
              acc_d     = {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
              opb_d     = op[1] ? b_mag : a_mag;
              is_div_d  = op[1];
              neg_res_d = a_neg ^ b_neg;
              neg_rem_d = a_neg;
              divz_d    = op[1] & (b == {WIDTH{1'b0}});
              dbz_d     = 1'b0;
            end
            3'b100: begin
              hi_d   = a;
              done_d = 1'b1;
              dbz_d  = 1'b0;
            end
            3'b101: begin
              lo_d   = a;
              done_d = 1'b1;
              dbz_d  = 1'b0;
            end
            default: ;
          endcase
        end
      end

      S_CALC: begin
        if (is_div_q) begin
          acc_d = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                   acc_q[WIDTH-2:0], div_ge};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        if (is_div_q) begin
          // With a zero divisor the remainder path shifts the whole dividend
          // magnitude through, so re-applying the dividend sign restores raw a.
          hi_d = rem_fix;
          lo_d = divz_q ? {WIDTH{1'b1}} : quo_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        dbz_d   = divz_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      divz_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      divz_q    <= divz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign dbz  = dbz_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, dbz;
  logic [W-1:0] hi, lo;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .dbz   (dbz),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference arithmetic straight from the MIPS definitions, using wide ints.
  function automatic void ref_calc(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                   output logic [W-1:0] rh, output logic [W-1:0] rl, output logic rd);
    logic [2*W-1:0] u;
    longint sx, sy, sq, sr;
    rh = '0; rl = '0; rd = 1'b0; u = '0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      3'd0: begin u = {{W{1'b0}}, x} * {{W{1'b0}}, y}; rh = u[2*W-1:W]; rl = u[W-1:0]; end
      3'd1: begin u = sx * sy; rh = u[2*W-1:W]; rl = u[W-1:0]; end
      3'd2, 3'd3: begin
        if (y == '0) begin
          rh = x; rl = '1; rd = 1'b1;
        end else if (o == 3'd2) begin
          rl = x / y; rh = x % y;
        end else begin
          sq = sx / sy; sr = sx % sy;
          rl = sq[W-1:0]; rh = sr[W-1:0];
        end
      end
      default: ;
    endcase
  endfunction

  // Cycle model: an accepted mul/div lands its precomputed result LAT edges later.
  int           m_left = 0;
  logic         m_done = 1'b0, m_dbz = 1'b0, p_dbz = 1'b0;
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

  always @(posedge clk) begin : model
    logic [W-1:0] rh, rl;
    logic         rd;
    if (rst) begin
      m_left <= 0; m_done <= 1'b0; m_dbz <= 1'b0; m_hi <= '0; m_lo <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_left != 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_hi <= p_hi; m_lo <= p_lo; m_dbz <= p_dbz; m_done <= 1'b1;
        end
      end else if (start && !(op[2] && op[1])) begin
        m_dbz <= 1'b0;
        if (!op[2]) begin
          ref_calc(op, a, b, rh, rl, rd);
          p_hi <= rh; p_lo <= rl; p_dbz <= rd;
          m_left <= LAT;
        end else begin
          if (op[0]) m_lo <= a; else m_hi <= a;
          m_done <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, m_left != 0);
      check("done", done, m_done);
      check("dbz",  dbz,  m_dbz);
      check("hi",   hi,   m_hi);
      check("lo",   lo,   m_lo);
    end
  end

  // Issue one op, then wait (bounded) for done. junk=1 scribbles random
  // inputs while busy; junk=2 fires a single MTLO start mid-calculation.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int junk, output int lat, output int bcyc);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; lat = 0; bcyc = 0;
    while (!done && lat < 80) begin
      bcyc += int'(busy);
      if (junk == 1) begin
        start = 1'($urandom_range(0, 1)); op = 3'($urandom); a = $urandom; b = $urandom;
      end else if (junk == 2) begin
        start = (lat == 5); op = 3'd5; a = 32'h0000DEAD;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return 32'd1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  logic [W-1:0] t_hi, t_lo;
  logic         t_dbz;
  int           lat, bc, dcount, r;
  logic [2:0]   o;

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    rst = 1'b0;

    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbz",  dbz,  0);
    check("rst_hi",   hi,   0);
    check("rst_lo",   lo,   0);

    // Pin the reference model with hand-computed values.
    ref_calc(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, t_hi, t_lo, t_dbz);
    check("ref_multu_hi", t_hi, 32'hFFFFFFFE);
    check("ref_multu_lo", t_lo, 32'h00000001);
    ref_calc(3'd3, 32'hFFFFFFF9, 32'd2, t_hi, t_lo, t_dbz);
    check("ref_div_lo", t_lo, 32'hFFFFFFFD);
    check("ref_div_hi", t_hi, 32'hFFFFFFFF);
    ref_calc(3'd3, 32'h80000000, 32'hFFFFFFFF, t_hi, t_lo, t_dbz);
    check("ref_ovf_lo", t_lo, 32'h80000000);
    check("ref_ovf_hi", t_hi, 32'h0);
    ref_calc(3'd2, 32'h1234, 32'h0, t_hi, t_lo, t_dbz);
    check("ref_dbz", {t_dbz, t_hi, t_lo}, {1'b1, 32'h1234, 32'hFFFFFFFF});

    // Directed cases; each start lands in the previous op's done cycle.
    run_op(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, lat, bc);
    check("multu_lat", lat, LAT);
    check("multu_busy_cycles", bc, LAT);
    check("multu_hi", hi, 32'hFFFFFFFE);
    check("multu_lo", lo, 32'h00000001);

    run_op(3'd1, 32'hFFFFFFFD, 32'd7, 0, lat, bc);
    check("mult_lat", lat, LAT);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFEB);

    run_op(3'd2, 32'd100, 32'd7, 2, lat, bc);
    check("divu_lat", lat, LAT);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);

    run_op(3'd3, 32'hFFFFFFF9, 32'd2, 0, lat, bc);
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);

    run_op(3'd2, 32'h1234, 32'h0, 0, lat, bc);
    check("dbz_lat", lat, LAT);
    check("dbz_hi", hi, 32'h1234);
    check("dbz_lo", lo, 32'hFFFFFFFF);
    check("dbz_flag", dbz, 1);

    run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 0, lat, bc);
    check("ovf_lo", lo, 32'h80000000);
    check("ovf_hi", hi, 32'h0);
    check("ovf_dbz", dbz, 0);

    run_op(3'd4, 32'h0000CAFE, 32'h0, 0, lat, bc);
    check("mthi_lat", lat, 0);
    check("mthi_done", done, 1);
    check("mthi_hi", hi, 32'h0000CAFE);

    // Op 11x must do nothing.
    start = 1'b1; op = 3'd6; a = 32'h1; b = 32'h1;
    @(posedge clk); #1;
    start = 1'b0;
    check("ign_done", done, 0);
    check("ign_busy", busy, 0);
    check("ign_hi", hi, 32'h0000CAFE);

    // Reset in the 10th CALC cycle of a MULT aborts it silently.
    start = 1'b1; op = 3'd1; a = 32'h12345678; b = 32'h9ABCDEF1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    dcount = 0;
    repeat (40) begin @(posedge clk); #1; dcount += int'(done); end
    check("abort_no_done", dcount, 0);

    // Randomised mix with junk on the inputs while busy.
    for (int i = 0; i < 1000; i++) begin
      r = int'($urandom_range(0, 19));
      if (r < 16)      o = 3'(r % 4);
      else if (r < 18) o = 3'(r - 12);
      else             o = 3'(r - 12);
      if (o[2] && o[1]) begin
        start = 1'b1; op = o; a = $urandom; b = $urandom;
        @(posedge clk); #1;
        start = 1'b0;
        check("rand_ign_done", done, 0);
      end else begin
        run_op(o, rnd_operand(), rnd_operand(), 1, lat, bc);
        check("rand_lat", lat, o[2] ? 0 : LAT);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
